// File: rtl/sprite_row_scheduler.sv
// Per-scanline sprite row sequencer with a host attribute-write queue
// that only drains into the engine's attribute RAM between row builds.
module sprite_row_scheduler #(
    parameter  int NUM_SPRITE = 32,
    parameter  int FIFO_DEPTH = 8,
    parameter  int H_TRIGGER  = 640,
    localparam int IW         = $clog2(NUM_SPRITE)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [10:0]   hcount,
    input  logic [9:0]    vcount,
    input  logic          host_wr,
    input  logic [IW-1:0] host_idx,
    input  logic [31:0]   host_data,
    input  logic          clear_flags,
    input  logic          eng_done,
    output logic          sprite_start,
    output logic          spr_wr_en,
    output logic [IW-1:0] spr_wr_idx,
    output logic [31:0]   spr_wr_data,
    output logic          lb_draw_sel,
    output logic          busy,
    output logic          fifo_full,
    output logic          overrun,
    output logic          drop,
    output logic [7:0]    overrun_cnt
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = IW + 32;

    typedef enum logic {
        IDLE,
        RUN
    } state_e;

    state_e        state_q, state_d;
    logic [1:0]    guard_q, guard_d;
    logic          start_q, start_d;
    logic          lb_q, lb_d;
    logic          ovr_q, ovr_d;
    logic [7:0]    cnt_q, cnt_d;
    logic          drop_q, drop_d;

    logic [AW:0]   count_q, count_d;
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic          full_q;
    logic [EW-1:0] mem [FIFO_DEPTH];

    logic          wen_q;
    logic [IW-1:0] widx_q;
    logic [31:0]   wdata_q;

    logic trig;
    logic full;
    logic push;
    logic pop;

    // Vblank lines 479..523 never launch a row; 524 preloads line 0.
    assign trig = (hcount == 11'(H_TRIGGER))
               && ((vcount < 10'd479) || (vcount == 10'd524));

    assign full = (count_q == (AW+1)'(FIFO_DEPTH));
    assign push = host_wr && !full;

    // Keep the RAM quiet around the launch so the row sees a stable table.
    assign pop  = (count_q != '0)
               && (state_q == IDLE)
               && !trig
               && (hcount != 11'(H_TRIGGER - 1))
               && (hcount != 11'(H_TRIGGER));

    always_comb begin
        state_d = state_q;
        guard_d = guard_q;
        start_d = 1'b0;
        lb_d    = lb_q;
        ovr_d   = ovr_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (trig) begin
                    start_d = 1'b1;
                    lb_d    = ~lb_q;
                    guard_d = 2'd2;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (guard_q != 2'd0) begin
                    guard_d = guard_q - 2'd1;
                end
                if (trig) begin
                    ovr_d = 1'b1;
                    if (cnt_q != 8'hFF) begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end else if ((guard_q == 2'd0) && eng_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (clear_flags) begin
            ovr_d = 1'b0;
            cnt_d = 8'd0;
        end
    end

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
        drop_d = drop_q | (host_wr & full);
        if (clear_flags) begin
            drop_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            guard_q <= 2'd0;
            start_q <= 1'b0;
            lb_q    <= 1'b0;
            ovr_q   <= 1'b0;
            cnt_q   <= 8'd0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            guard_q <= guard_d;
            start_q <= start_d;
            lb_q    <= lb_d;
            ovr_q   <= ovr_d;
            cnt_q   <= cnt_d;
            drop_q  <= drop_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            full_q   <= 1'b0;
            wen_q    <= 1'b0;
            widx_q   <= '0;
            wdata_q  <= '0;
        end else begin
            count_q <= count_d;
            full_q  <= (count_d == (AW+1)'(FIFO_DEPTH));
            wen_q   <= pop;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
                {widx_q, wdata_q} <= mem[rd_ptr_q];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= {host_idx, host_data};
        end
    end

    assign sprite_start = start_q;
    assign spr_wr_en    = wen_q;
    assign spr_wr_idx   = widx_q;
    assign spr_wr_data  = wdata_q;
    assign lb_draw_sel  = lb_q;
    assign busy         = (state_q == RUN);
    assign fifo_full    = full_q;
    assign overrun      = ovr_q;
    assign drop         = drop_q;
    assign overrun_cnt  = cnt_q;

endmodule

// File: tb/tb_sprite_row_scheduler.sv
// Directed and randomized checks of the sprite row scheduler against
// a queue-based model of the host write path.
module tb_sprite_row_scheduler;

    localparam int IW = 5;

    typedef struct {
        logic [IW-1:0] idx;
        logic [31:0]   data;
    } wr_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [10:0]   hcount = 11'd0;
    logic [9:0]    vcount = 10'd10;
    logic          host_wr = 1'b0;
    logic [IW-1:0] host_idx = '0;
    logic [31:0]   host_data = '0;
    logic          clear_flags = 1'b0;
    logic          eng_done = 1'b0;
    logic          sprite_start;
    logic          spr_wr_en;
    logic [IW-1:0] spr_wr_idx;
    logic [31:0]   spr_wr_data;
    logic          lb_draw_sel;
    logic          busy;
    logic          fifo_full;
    logic          overrun;
    logic          drop;
    logic [7:0]    overrun_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    sprite_row_scheduler dut (
        .clk         (clk),
        .reset       (reset),
        .hcount      (hcount),
        .vcount      (vcount),
        .host_wr     (host_wr),
        .host_idx    (host_idx),
        .host_data   (host_data),
        .clear_flags (clear_flags),
        .eng_done    (eng_done),
        .sprite_start(sprite_start),
        .spr_wr_en   (spr_wr_en),
        .spr_wr_idx  (spr_wr_idx),
        .spr_wr_data (spr_wr_data),
        .lb_draw_sel (lb_draw_sel),
        .busy        (busy),
        .fifo_full   (fifo_full),
        .overrun     (overrun),
        .drop        (drop),
        .overrun_cnt (overrun_cnt)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".start"}, 32'(sprite_start), 0);
        chk({tag, ".wen"},   32'(spr_wr_en), 0);
        chk({tag, ".widx"},  32'(spr_wr_idx), 0);
        chk({tag, ".wdata"}, spr_wr_data, 0);
        chk({tag, ".lb"},    32'(lb_draw_sel), 0);
        chk({tag, ".busy"},  32'(busy), 0);
        chk({tag, ".full"},  32'(fifo_full), 0);
        chk({tag, ".ovr"},   32'(overrun), 0);
        chk({tag, ".drop"},  32'(drop), 0);
        chk({tag, ".ocnt"},  32'(overrun_cnt), 0);
    endtask

    wr_t           q[$];
    wr_t           e;
    logic          exp_en;
    logic          exp_drop;
    logic          full_now;
    int            seen;
    logic [IW-1:0] s_idx [3];
    logic [31:0]   s_dat [3];

    initial begin
        cyc();
        cyc();
        chk_reset_vals("reset");
        reset = 1'b1;
        hcount = 11'd600;
        cyc();

        // Basic row: done arrives late
        hcount = 11'd640;
        cyc();
        chk("r1.start", 32'(sprite_start), 1);
        chk("r1.lb", 32'(lb_draw_sel), 1);
        chk("r1.busy", 32'(busy), 1);
        hcount = 11'd641;
        for (int k = 2; k <= 5; k++) begin
            cyc();
            chk("r1.start_once", 32'(sprite_start), 0);
            chk("r1.busy_hold", 32'(busy), 1);
        end
        eng_done = 1'b1;
        cyc();
        chk("r1.busy_fall", 32'(busy), 0);
        chk("r1.nostart", 32'(sprite_start), 0);

        // Done held high: guard keeps busy for 3 cycles
        vcount = 10'd20;
        hcount = 11'd640;
        cyc();
        chk("r2.start", 32'(sprite_start), 1);
        chk("r2.lb", 32'(lb_draw_sel), 0);
        hcount = 11'd641;
        cyc();
        chk("r2.busy2", 32'(busy), 1);
        chk("r2.start_once", 32'(sprite_start), 0);
        cyc();
        chk("r2.busy3", 32'(busy), 1);
        cyc();
        chk("r2.busy_fall", 32'(busy), 0);
        chk("r2.nostart", 32'(sprite_start), 0);

        // Vblank suppression and line 524
        eng_done = 1'b0;
        vcount = 10'd500;
        hcount = 11'd640;
        cyc();
        chk("vb.start", 32'(sprite_start), 0);
        chk("vb.busy", 32'(busy), 0);
        chk("vb.lb", 32'(lb_draw_sel), 0);
        vcount = 10'd524;
        cyc();
        chk("v524.start", 32'(sprite_start), 1);
        chk("v524.lb", 32'(lb_draw_sel), 1);
        hcount = 11'd641;
        eng_done = 1'b1;
        cyc();
        cyc();
        cyc();
        chk("v524.done", 32'(busy), 0);

        // Overrun, then clear beating a same-cycle overrun
        eng_done = 1'b0;
        vcount = 10'd30;
        hcount = 11'd640;
        cyc();
        chk("ov.start", 32'(sprite_start), 1);
        hcount = 11'd641;
        cyc();
        cyc();
        cyc();
        hcount = 11'd640;
        cyc();
        chk("ov.nostart", 32'(sprite_start), 0);
        chk("ov.lb", 32'(lb_draw_sel), 0);
        chk("ov.flag", 32'(overrun), 1);
        chk("ov.cnt", 32'(overrun_cnt), 1);
        chk("ov.busy", 32'(busy), 1);
        clear_flags = 1'b1;
        cyc();
        chk("ov.clr_flag", 32'(overrun), 0);
        chk("ov.clr_cnt", 32'(overrun_cnt), 0);
        clear_flags = 1'b0;
        hcount = 11'd641;
        eng_done = 1'b1;
        cyc();
        chk("ov.end", 32'(busy), 0);
        eng_done = 1'b0;

        // Ten writes during a row: eight queued, two dropped
        vcount = 10'd40;
        hcount = 11'd640;
        cyc();
        hcount = 11'd641;
        for (int i = 0; i < 10; i++) begin
            host_wr = 1'b1;
            host_idx = IW'(i);
            host_data = 32'hA000_0000 + 32'(i);
            cyc();
            chk("fq.noen", 32'(spr_wr_en), 0);
        end
        host_wr = 1'b0;
        chk("fq.full", 32'(fifo_full), 1);
        chk("fq.drop", 32'(drop), 1);
        chk("fq.busy", 32'(busy), 1);
        eng_done = 1'b1;
        cyc();
        chk("fq.idle", 32'(busy), 0);
        eng_done = 1'b0;
        for (int k = 0; k < 8; k++) begin
            cyc();
            chk("fq.en", 32'(spr_wr_en), 1);
            chk("fq.idx", 32'(spr_wr_idx), k);
            chk("fq.data", spr_wr_data, 32'hA000_0000 + 32'(k));
            if (k == 0) chk("fq.notfull", 32'(fifo_full), 0);
        end
        cyc();
        chk("fq.drained", 32'(spr_wr_en), 0);
        clear_flags = 1'b1;
        cyc();
        clear_flags = 1'b0;
        chk("fq.dropclr", 32'(drop), 0);

        // Writes straddling the launch window
        vcount = 10'd50;
        seen = 0;
        for (int hc = 637; hc <= 660; hc++) begin
            hcount = 11'(hc);
            host_wr = (hc <= 639);
            host_idx = IW'(20 + hc - 637);
            host_data = 32'hB000_0000 + 32'(hc);
            eng_done = (hc >= 643);
            chk("win.excl_start", 32'(spr_wr_en & sprite_start), 0);
            chk("win.excl_busy", 32'(spr_wr_en & busy), 0);
            chk("win.gate_h", 32'(spr_wr_en & (hc == 640 || hc == 641)), 0);
            if (spr_wr_en && seen < 3) begin
                s_idx[seen] = spr_wr_idx;
                s_dat[seen] = spr_wr_data;
            end
            if (spr_wr_en) seen++;
            cyc();
        end
        host_wr = 1'b0;
        eng_done = 1'b0;
        chk("win.count", 32'(seen), 3);
        for (int k = 0; k < 3; k++) begin
            chk("win.idx", 32'(s_idx[k]), 20 + k);
            chk("win.data", s_dat[k], 32'hB000_0000 + 32'(637 + k));
        end

        // Reset in the middle of a row with writes pending
        vcount = 10'd60;
        hcount = 11'd640;
        cyc();
        hcount = 11'd641;
        for (int i = 0; i < 3; i++) begin
            host_wr = 1'b1;
            host_idx = IW'(i + 5);
            host_data = 32'hC000_0000 + 32'(i);
            cyc();
        end
        host_wr = 1'b0;
        chk("rst.busy_before", 32'(busy), 1);
        reset = 1'b0;
        #1;
        chk_reset_vals("rst_mid");
        cyc();
        reset = 1'b1;
        vcount = 10'd500;
        hcount = 11'd100;
        for (int k = 0; k < 5; k++) begin
            cyc();
            chk("rst.fifo_empty", 32'(spr_wr_en), 0);
            chk("rst.nostart", 32'(sprite_start), 0);
        end

        // Randomized host traffic in vblank against the queue model
        exp_drop = 1'b0;
        q.delete();
        for (int n = 0; n < 400; n++) begin
            hcount = ($urandom_range(0, 3) == 0) ? 11'($urandom_range(0, 799))
                                                 : 11'(639 + $urandom_range(0, 1));
            host_wr = ($urandom_range(0, 2) != 0);
            host_idx = IW'($urandom);
            host_data = $urandom;
            clear_flags = ($urandom_range(0, 15) == 0);
            full_now = (q.size() == 8);
            exp_en = (q.size() != 0) && (hcount != 11'd639) && (hcount != 11'd640);
            if (exp_en) e = q.pop_front();
            if (host_wr) begin
                if (full_now) exp_drop = 1'b1;
                else q.push_back('{idx: host_idx, data: host_data});
            end
            if (clear_flags) exp_drop = 1'b0;
            cyc();
            chk("rnd.en", 32'(spr_wr_en), 32'(exp_en));
            if (exp_en) begin
                chk("rnd.idx", 32'(spr_wr_idx), 32'(e.idx));
                chk("rnd.data", spr_wr_data, e.data);
            end
            chk("rnd.full", 32'(fifo_full), 32'(q.size() == 8));
            chk("rnd.drop", 32'(drop), 32'(exp_drop));
            chk("rnd.busy", 32'(busy), 0);
        end
        host_wr = 1'b0;
        clear_flags = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
